// File: rtl/n8md_pkg.sv
// Shared types and defaults for the bit-serial decrementer.
package n8md_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } n8md_state_t;

    localparam int N_DEFAULT = 8;

endpackage

// File: rtl/n8md_serial_decrementer_hs_cell.sv
// 1-bit half-subtractor: difference and borrow-out of a - bi.
module hs_cell (
    input  logic a,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ bi;
    assign bo = ~a & bi;

endmodule

// File: rtl/n8md_serial_decrementer.sv
// Bit-serial N-bit decrementer: result = aa - ci (mod 2^N), one bit per clock, LSB first.
module n8md_serial_decrementer
    import n8md_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] aa,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         bo
);

    localparam int CNT_W = $clog2(N);

    n8md_state_t      state_r;
    logic [N-1:0]     sr_r;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [N-1:0]     result_r;
    logic             bo_r;

    logic             d_s;
    logic             bo_s;

    hs_cell u_hs_cell (
        .a  (sr_r[0]),
        .bi (borrow_r),
        .d  (d_s),
        .bo (bo_s)
    );

    // FSM, shift register, borrow flop, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            sr_r     <= {N{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {N{1'b0}};
            bo_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE for back-to-back operation
                    done_r <= 1'b0;
                    if (start) begin
                        sr_r     <= aa;
                        borrow_r <= ci;
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    sr_r     <= {d_s, sr_r[N-1:1]};
                    borrow_r <= bo_s;
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(N - 1)) begin
                        result_r <= {d_s, sr_r[N-1:1]};
                        bo_r     <= bo_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign bo     = bo_r;

endmodule

// File: tb/tb_n8md_serial_decrementer.sv
// Self-checking bench: directed, randomized and exhaustive checks against an arithmetic model.
module tb_n8md_serial_decrementer;

    localparam int N   = 8;
    localparam int LAT = N + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] aa;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         bo;

    int total;
    int bad;

    logic [N-1:0] exp_last_res;
    logic         exp_last_bo;

    n8md_serial_decrementer #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .aa     (aa),
        .ci     (ci),
        .busy   (busy),
        .done   (done),
        .result (result),
        .bo     (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {borrow, difference} of aa - ci using plain wide arithmetic
    function automatic logic [N:0] ref_dec(input logic [N-1:0] a, input logic c);
        logic [N:0] t;
        t = {1'b0, a} - {{N{1'b0}}, c};
        return t;
    endfunction

    // Drive one operation and report observed result, borrow and edges from acceptance to done
    task automatic do_op(input logic [N-1:0] a, input logic c,
                         output logic [N-1:0] r, output logic b, output int lat);
        bit found;
        found = 1'b0;
        r = '0;
        b = 1'b0;
        @(negedge clk);
        start = 1'b1;
        aa = a;
        ci = c;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        aa = N'($urandom);
        ci = 1'($urandom);
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                r = result;
                b = bo;
            end
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, result, bo} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b result=%h bo=%b, required all zero", busy, done, result, bo);
        end
        rst = 1'b1;
        exp_last_res = '0;
        exp_last_bo  = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] va [4];
        logic         vc [4];
        logic [N-1:0] r;
        logic         b;
        logic [N:0]   e;
        int           lat;
        va[0] = 8'h00; vc[0] = 1'b1;
        va[1] = 8'h80; vc[1] = 1'b1;
        va[2] = 8'h01; vc[2] = 1'b1;
        va[3] = 8'h5A; vc[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vc[i], r, b, lat);
            e = ref_dec(va[i], vc[i]);
            total++;
            if (r !== e[N-1:0]) begin
                bad++;
                $display("FAIL directed_result aa=%h ci=%b: got %h, required %h", va[i], vc[i], r, e[N-1:0]);
            end
            total++;
            if (b !== e[N]) begin
                bad++;
                $display("FAIL directed_bo aa=%h ci=%b: got %b, required %b", va[i], vc[i], b, e[N]);
            end
            total++;
            if (lat != LAT) begin
                bad++;
                $display("FAIL directed_latency aa=%h ci=%b: got %0d, required %0d", va[i], vc[i], lat, LAT);
            end
            exp_last_res = e[N-1:0];
            exp_last_bo  = e[N];
        end
    endtask

    task automatic test_start_ignored();
        bit  seen;
        int  lat;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        aa = 8'h20;
        ci = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL ignore_busy edge %0d: got %b, required 1", lat, busy);
                end
                total++;
                if ({bo, result} !== {exp_last_bo, exp_last_res}) begin
                    bad++;
                    $display("FAIL ignore_hold edge %0d: got bo=%b result=%h, required bo=%b result=%h",
                             lat, bo, result, exp_last_bo, exp_last_res);
                end
                if (lat == 3) begin
                    start = 1'b1;
                    aa = 8'h33;
                end else begin
                    start = 1'b0;
                end
            end
        end
        total++;
        if (lat != LAT || result !== 8'h1F || bo !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result: lat=%0d result=%h bo=%b, required lat=%0d result=1f bo=0",
                     lat, result, bo, LAT);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_after: done=%b busy=%b, required 0 0", done, busy);
        end
        exp_last_res = 8'h1F;
        exp_last_bo  = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int lat;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        aa = 8'h44;
        ci = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen || result !== 8'h43) begin
            bad++;
            $display("FAIL b2b_first: seen=%0d result=%h, required 1 43", seen, result);
        end
        aa = 8'h10;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen || lat != LAT || result !== 8'h0F || bo !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: seen=%0d lat=%0d result=%h bo=%b, required 1 %0d 0f 0",
                     seen, lat, result, bo, LAT);
        end
        exp_last_res = 8'h0F;
        exp_last_bo  = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        aa = 8'h77;
        ci = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        total++;
        if ({busy, done, result, bo} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h bo=%b, required all zero", busy, done, result, bo);
        end
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet cycle %0d: done=%b busy=%b, required 0 0", k, done, busy);
            end
        end
        exp_last_res = '0;
        exp_last_bo  = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic         c;
        logic [N-1:0] r;
        logic         b;
        logic [N:0]   e;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            c = 1'($urandom);
            do_op(a, c, r, b, lat);
            e = ref_dec(a, c);
            total++;
            if ({b, r} !== e || lat != LAT) begin
                bad++;
                $display("FAIL random aa=%h ci=%b: got bo=%b result=%h lat=%0d, required bo=%b result=%h lat=%0d",
                         a, c, b, r, lat, e[N], e[N-1:0], LAT);
            end
        end
    endtask

    task automatic test_sweep();
        logic [N-1:0] a;
        logic [N-1:0] r;
        logic         b;
        logic [N:0]   e;
        int           lat;
        for (int i = 0; i < (1 << N); i++) begin
            a = N'(i);
            do_op(a, 1'b1, r, b, lat);
            e = {(a == '0), a - {{(N-1){1'b0}}, 1'b1}};
            total++;
            if ({b, r} !== e || lat != LAT) begin
                bad++;
                $display("FAIL sweep aa=%h: got bo=%b result=%h lat=%0d, required bo=%b result=%h lat=%0d",
                         a, b, r, lat, e[N], e[N-1:0], LAT);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start = 1'b0;
        aa    = '0;
        ci    = 1'b0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
